// File: rtl/alarm_pkg.sv
// Shared encodings and widths for the alarm ring sequencer.
package alarm_pkg;

  localparam int BCD_TIME_W = 24;
  localparam int SECS_W     = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } ring_state_e;

endpackage

// File: rtl/phase_timer.sv
// Loadable down counter shared by the RINGING and SNOOZE phases.
// Saturates at zero; done flags the tick that consumes the last second.
module phase_timer
  import alarm_pkg::*;
#(
  parameter int W = SECS_W
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_tick,
  output logic [W-1:0] o_cnt,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // Clear beats load beats tick; count holds at zero instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_reset)                   r_cnt <= '0;
    else if (i_clr)                 r_cnt <= '0;
    else if (i_load)                r_cnt <= i_load_val;
    else if (i_tick && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt  = r_cnt;
  assign o_done = i_tick & (r_cnt == W'(1));

endmodule

// File: rtl/alarm_ring_sequencer.sv
// Alarm ring controller: detects the rising edge of the time match and
// sequences IDLE / RINGING / SNOOZE with snooze limit, stop and timeout.
module alarm_ring_sequencer
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_sec_tick,
  input  logic [BCD_TIME_W-1:0] i_cur_time,
  input  logic [BCD_TIME_W-1:0] i_alm_time,
  input  logic                  i_alarm_on,
  input  logic                  i_snooze_key,
  input  logic                  i_stop_key,
  output logic                  o_play_sound,
  output logic [1:0]            o_ring_state,
  output logic [1:0]            o_snooze_cnt,
  output logic [SECS_W-1:0]     o_secs_left
);

  localparam logic [SECS_W-1:0] LP_RING   = SECS_W'(RING_SECS);
  localparam logic [SECS_W-1:0] LP_SNOOZE = SECS_W'(SNOOZE_SECS);
  localparam logic [1:0]        LP_MAX    = 2'(MAX_SNOOZE);

  ring_state_e        r_state;
  logic [1:0]         r_snooze_cnt;
  logic               r_match_q;
  logic               r_play;

  ring_state_e        w_nxt_state;
  logic [1:0]         w_nxt_snz;
  logic               w_clr;
  logic               w_load;
  logic [SECS_W-1:0]  w_load_val;
  logic               w_tick;
  logic               w_done;
  logic [SECS_W-1:0]  w_secs;
  logic               w_match;
  logic               w_trigger;
  logic               w_snz_ok;

  assign w_match   = (i_cur_time == i_alm_time);
  // One event per matching second; match_q resets high so power-up 00:00:00 is silent.
  assign w_trigger = w_match & ~r_match_q;
  assign w_snz_ok  = i_snooze_key & (r_snooze_cnt < LP_MAX);

  // A second only counts when no key transition claims this cycle.
  assign w_tick = i_sec_tick & i_alarm_on & ~i_stop_key &
                  (((r_state == ST_RINGING) & ~w_snz_ok) | (r_state == ST_SNOOZE));

  phase_timer #(.W(SECS_W)) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clr      (w_clr),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_tick     (w_tick),
    .o_cnt      (w_secs),
    .o_done     (w_done)
  );

  // Next-state and timer control, priority: enable, stop, snooze, trigger, tick.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_snz   = r_snooze_cnt;
    w_clr       = 1'b0;
    w_load      = 1'b0;
    w_load_val  = LP_RING;
    if (!i_alarm_on) begin
      w_nxt_state = ST_IDLE;
      w_nxt_snz   = 2'd0;
      w_clr       = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            w_nxt_state = ST_RINGING;
            w_load      = 1'b1;
          end
        end
        ST_RINGING: begin
          if (i_stop_key) begin
            w_nxt_state = ST_IDLE;
            w_nxt_snz   = 2'd0;
            w_clr       = 1'b1;
          end else if (w_snz_ok) begin
            w_nxt_state = ST_SNOOZE;
            w_nxt_snz   = r_snooze_cnt + 2'd1;
            w_load      = 1'b1;
            w_load_val  = LP_SNOOZE;
          end else if (w_done) begin
            // Ring timeout: the tick itself drains the timer to zero.
            w_nxt_state = ST_IDLE;
            w_nxt_snz   = 2'd0;
          end
        end
        ST_SNOOZE: begin
          if (i_stop_key) begin
            w_nxt_state = ST_IDLE;
            w_nxt_snz   = 2'd0;
            w_clr       = 1'b1;
          end else if (w_done) begin
            w_nxt_state = ST_RINGING;
            w_load      = 1'b1;
          end
        end
        default: begin
          w_nxt_state = ST_IDLE;
          w_nxt_snz   = 2'd0;
          w_clr       = 1'b1;
        end
      endcase
    end
  end

  // State, snooze count, match history and the registered sound enable.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_snooze_cnt <= 2'd0;
      r_match_q    <= 1'b1;
      r_play       <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_snooze_cnt <= w_nxt_snz;
      r_match_q    <= w_match;
      r_play       <= (w_nxt_state == ST_RINGING);
    end
  end

  assign o_play_sound = r_play;
  assign o_ring_state = r_state;
  assign o_snooze_cnt = r_snooze_cnt;
  assign o_secs_left  = w_secs;

endmodule

// File: tb/tb_alarm_ring_sequencer.sv
// Directed scenarios plus randomized traffic, compared cycle by cycle
// against a behavioural model of the alarm rules.
module tb_alarm_ring_sequencer;

  localparam int RING   = 5;
  localparam int SNOOZE = 3;
  localparam int MAXS   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sec_tick;
  logic [23:0] cur_time, alm_time;
  logic        alarm_on, snooze_key, stop_key;
  logic        play_sound;
  logic [1:0]  ring_state, snooze_cnt;
  logic [8:0]  secs_left;

  int n_chk = 0;
  int n_err = 0;
  int tcnt  = 0;

  // model: mode 0 idle, 1 ringing, 2 snooze
  int m_mode, m_secs, m_cnt, m_play, m_prev_match;

  always #5 clk = ~clk;

  alarm_ring_sequencer #(
    .RING_SECS(RING), .SNOOZE_SECS(SNOOZE), .MAX_SNOOZE(MAXS)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_sec_tick(sec_tick),
    .i_cur_time(cur_time), .i_alm_time(alm_time), .i_alarm_on(alarm_on),
    .i_snooze_key(snooze_key), .i_stop_key(stop_key),
    .o_play_sound(play_sound), .o_ring_state(ring_state),
    .o_snooze_cnt(snooze_cnt), .o_secs_left(secs_left)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic go_idle();
    m_mode = 0; m_secs = 0; m_cnt = 0;
  endtask

  // What one clock edge does to the alarm, given the inputs present before it.
  task automatic model_edge();
    int is_match, fresh;
    is_match = (cur_time == alm_time);
    if (!rst_n) begin
      go_idle(); m_play = 0; m_prev_match = 1;
      return;
    end
    fresh = is_match && !m_prev_match;
    m_prev_match = is_match;
    if (!alarm_on) go_idle();
    else if (m_mode == 0) begin
      if (fresh) begin m_mode = 1; m_secs = RING; end
    end else if (m_mode == 1) begin
      if (stop_key) go_idle();
      else if (snooze_key && m_cnt < MAXS) begin
        m_mode = 2; m_cnt++; m_secs = SNOOZE;
      end else if (sec_tick) begin
        if (m_secs == 1) go_idle(); else m_secs--;
      end
    end else begin
      if (stop_key) go_idle();
      else if (sec_tick) begin
        if (m_secs == 1) begin m_mode = 1; m_secs = RING; end
        else m_secs--;
      end
    end
    m_play = (m_mode == 1);
  endtask

  task automatic step(input logic st, input logic sn);
    @(negedge clk);
    stop_key   = st;
    snooze_key = sn;
    sec_tick   = (tcnt == 9);
    tcnt       = (tcnt == 9) ? 0 : tcnt + 1;
    model_edge();
    @(posedge clk);
    #1;
    chk("play_sound", play_sound, m_play);
    chk("ring_state", ring_state, m_mode);
    chk("snooze_cnt", snooze_cnt, m_cnt);
    chk("secs_left",  secs_left,  m_secs);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic fire();
    cur_time = 24'h070004; run(2);
    cur_time = 24'h070005; run(1);
  endtask

  initial begin
    rst_n = 1'b0; sec_tick = 1'b0; stop_key = 1'b0; snooze_key = 1'b0;
    cur_time = 24'h0; alm_time = 24'h0; alarm_on = 1'b1;
    m_mode = 0; m_secs = 0; m_cnt = 0; m_play = 0; m_prev_match = 1;

    // 1: reset with equal zero times must stay silent
    run(2);
    rst_n = 1'b1;
    run(100);

    // 2: ring on rising match, time out after RING ticks, no retrigger
    alm_time = 24'h070005;
    fire();
    chk("ring_start_play", play_sound, 1);
    chk("ring_start_secs", secs_left, RING);
    run(60);
    chk("timeout_idle", ring_state, 0);

    // 3: snooze twice, third snooze ignored
    fire();
    step(1'b0, 1'b1);
    chk("snooze1_cnt", snooze_cnt, 1);
    run(35);
    chk("rering_state", ring_state, 1);
    step(1'b0, 1'b1);
    run(35);
    step(1'b0, 1'b1);
    chk("snooze_limit_play", play_sound, 1);
    run(5);
    step(1'b1, 1'b0);

    // 4: stop and snooze together, stop wins
    fire();
    step(1'b1, 1'b1);
    chk("stop_wins_state", ring_state, 0);

    // 5: alarm_on drop in snooze, no ring on re-enable with unchanged match
    fire();
    step(1'b0, 1'b1);
    alarm_on = 1'b0; run(1);
    chk("disable_idle", ring_state, 0);
    alarm_on = 1'b1; run(20);

    // 6: reset mid-ring
    fire();
    run(22);
    rst_n = 1'b0; run(1);
    rst_n = 1'b1; run(20);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) alm_time = $urandom & 24'hFFFFFF;
      if ($urandom_range(0, 5) == 0)
        cur_time = ($urandom_range(0, 1) == 0) ? alm_time : alm_time + 24'h1;
      alarm_on = ($urandom_range(0, 149) != 0);
      rst_n    = ($urandom_range(0, 599) != 0);
      step($urandom_range(0, 29) == 0, $urandom_range(0, 11) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
